// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns decoder memRead/memWrite into a single
// req/ack data-memory access, stalling the core until the access completes.
module lsu_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              fault
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nx;
    logic [TW-1:0] tcnt;
    logic [2:0]    ld_f3;
    logic [1:0]    ld_off;
    logic          is_ld;

    logic          f3_ok, aligned, accept, reject, timeout_hit;
    logic [3:0]    be_nx;
    logic [31:0]   wdata_nx, rd_sh, rd_ext;

    // Request decode: legality, alignment, lane enables, replicated store data
    always_comb begin
        f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = mem_read;
            default:                f3_ok = 1'b0;
        endcase

        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        be_nx    = 4'b1111;
        wdata_nx = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_nx    = 4'b0001 << addr[1:0];
                wdata_nx = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_nx    = 4'b0011 << addr[1:0];
                wdata_nx = {2{store_data[15:0]}};
            end
            default: begin
                be_nx    = 4'b1111;
                wdata_nx = store_data;
            end
        endcase
    end

    assign accept = (mem_read ^ mem_write) & f3_ok & aligned;
    assign reject = (mem_read | mem_write) & ~accept;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((32'(tcnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

    // Load lane extraction from the latched byte offset and size/sign
    always_comb begin
        rd_sh  = bus_rdata >> {ld_off, 3'b000};
        rd_ext = bus_rdata;
        case (ld_f3)
            3'b000:  rd_ext = {{24{rd_sh[7]}},  rd_sh[7:0]};
            3'b001:  rd_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b100:  rd_ext = {24'd0, rd_sh[7:0]};
            3'b101:  rd_ext = {16'd0, rd_sh[15:0]};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack || timeout_hit)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            ld_f3      <= '0;
            ld_off     <= '0;
            is_ld      <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nx;
            fault      <= 1'b0;
            load_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= be_nx;
                        bus_wdata <= wdata_nx;
                        ld_f3     <= funct3;
                        ld_off    <= addr[1:0];
                        is_ld     <= mem_read;
                        tcnt      <= '0;
                    end else if (reject) begin
                        fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        load_valid <= is_ld;
                        if (is_ld)
                            load_data <= rd_ext;
                    end else if (timeout_hit) begin
                        // Aborted access: loads still retire, with zero data
                        bus_req    <= 1'b0;
                        fault      <= 1'b1;
                        load_valid <= is_ld;
                        load_data  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed cases plus random loads/stores with a
// random-latency bus slave, checked each cycle against a transaction model.
module tb_lsu_bus_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic        stall, load_valid, bus_req, bus_we, fault;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int n_vec = 0, n_err = 0;
    logic [31:0] last_ld, last_wdata, last_addr;
    logic [3:0]  last_be;
    logic        last_we, last_fault;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
        .load_data(load_data), .load_valid(load_valid), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: access size in bytes from funct3
    function automatic int msize(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be = '0;
        int sz = msize(f3);
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w = '0;
        int sz = msize(f3);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int sz = msize(f3);
        logic [31:0] v, mask;
        if (sz == 4) return rd;
        v    = rd >> (8 * int'(a % 4));
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a);
        bit f3ok;
        if (rd == wr) return 1'b0;
        f3ok = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        if (!f3ok) return 1'b0;
        return (a % msize(f3)) == 0;
    endfunction

    // One instruction; ack_at = REQ cycle (1-based) carrying bus_ack, 0 = never
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int ack_at, input logic [31:0] rdata);
        bit legal = m_legal(rd, wr, f3, a);
        bit to;
        int n;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        bus_ack = 1'b0; bus_rdata = $urandom();
        #1;
        chk("issue_stall", stall, legal);
        chk("issue_req", bus_req, 0);
        chk("issue_lv", load_valid, 0);
        chk("issue_fault", fault, 0);
        if (!legal) begin
            @(negedge clk);
            mem_read = 0; mem_write = 0;
            #1;
            last_fault = fault;
            chk("rej_fault", fault, 1);
            chk("rej_req", bus_req, 0);
            chk("rej_stall", stall, 0);
            chk("rej_lv", load_valid, 0);
            return;
        end
        to = !(ack_at >= 1 && ack_at <= T);
        n  = to ? T : ack_at;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            bus_ack   = (!to && j == ack_at);
            bus_rdata = bus_ack ? rdata : $urandom();
            #1;
            chk("req_req", bus_req, 1);
            chk("req_stall", stall, 1);
            chk("req_we", bus_we, wr);
            chk("req_addr", bus_addr, a & 32'hFFFF_FFFC);
            chk("req_be", bus_be, m_be(f3, a));
            if (wr) chk("req_wdata", bus_wdata, m_wdata(f3, sd));
            chk("req_lv", load_valid, 0);
            chk("req_fault", fault, 0);
            last_be = bus_be; last_wdata = bus_wdata; last_we = bus_we; last_addr = bus_addr;
        end
        @(negedge clk);
        bus_ack = 1'b1;               // stray ack in DONE must be ignored
        bus_rdata = $urandom();
        #1;
        last_ld = load_data; last_fault = fault;
        chk("done_stall", stall, 0);
        chk("done_req", bus_req, 0);
        chk("done_lv", load_valid, rd);
        chk("done_fault", fault, to);
        if (rd) chk("done_data", load_data, to ? 32'd0 : m_load(f3, a, rdata));
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom();
        #1;
        chk("idle_stall", stall, 0);
        chk("idle_req", bus_req, 0);
        chk("idle_lv", load_valid, 0);
        chk("idle_fault", fault, 0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_lv", load_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases with hand-computed literals
        issue(1, 0, 3'b010, 32'h100, 32'd0, 2, 32'hDEADBEEF);
        chk("lw_lit_data", last_ld, 32'hDEADBEEF);
        chk("lw_lit_addr", last_addr, 32'h100);
        chk("lw_lit_be", {28'd0, last_be}, 32'hF);
        issue(1, 0, 3'b000, 32'h203, 32'd0, 1, 32'h80FF_0011);
        chk("lb_lit_data", last_ld, 32'hFFFF_FF80);
        chk("lb_lit_be", {28'd0, last_be}, 32'h8);
        issue(1, 0, 3'b100, 32'h203, 32'd0, 3, 32'h80FF_0011);
        chk("lbu_lit_data", last_ld, 32'h0000_0080);
        issue(0, 1, 3'b001, 32'h302, 32'h1234_ABCD, 1, 32'd0);
        chk("sh_lit_be", {28'd0, last_be}, 32'hC);
        chk("sh_lit_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_lit_we", {31'd0, last_we}, 32'd1);
        issue(1, 0, 3'b010, 32'h101, 32'd0, 1, 32'd0);
        chk("misal_lit_fault", {31'd0, last_fault}, 32'd1);
        issue(0, 1, 3'b011, 32'h104, 32'h55, 1, 32'd0);
        chk("sb011_lit_fault", {31'd0, last_fault}, 32'd1);
        idle_cyc();
        issue(1, 0, 3'b010, 32'h500, 32'd0, 0, 32'd0);
        chk("to_lit_data", last_ld, 32'd0);
        chk("to_lit_fault", {31'd0, last_fault}, 32'd1);
        idle_cyc();

        // reset during REQ, in-flight ack ignored, then a normal SW
        @(negedge clk);
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h400; bus_ack = 0;
        #1;
        chk("rreq_stall", stall, 1);
        @(negedge clk);
        #1;
        chk("rreq_req", bus_req, 1);
        @(negedge clk);
        rst_n = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; mem_read = 0;
        @(negedge clk);
        rst_n = 1'b1; bus_ack = 1'b0;
        #1;
        chk("rmid_req", bus_req, 0);
        chk("rmid_stall", stall, 0);
        chk("rmid_lv", load_valid, 0);
        chk("rmid_fault", fault, 0);
        chk("rmid_addr", bus_addr, 0);
        issue(0, 1, 3'b010, 32'h604, 32'h0BAD_C0DE, 2, 32'd0);
        chk("sw_after_rst_wdata", last_wdata, 32'h0BAD_C0DE);

        // randomized traffic
        for (int t = 0; t < 400; t++) begin
            int sel = $urandom_range(0, 19);
            bit rd = (sel < 10) || (sel == 19);
            bit wr = (sel >= 10);
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom();
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 7) == 0) idle_cyc();
            issue(rd, wr, f3, a, $urandom(), $urandom_range(0, 6), $urandom());
        end
        idle_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit controller that sits directly downstream of the main control decoder in the single-cycle core.
- Consumes memRead/memWrite plus the ALU-computed address, store data and funct3, and performs the access over a req/ack data-memory bus of variable latency.
- Stalls the core (freezes PC and register writeback) until the access completes.
- Returns size-adjusted, sign/zero-extended load data to the writeback mux (selected by memtoReg).
- Covers LW/LH/LB/LHU/LBU, SW/SH/SB, and FLW/FSW, which the decoder presents as word accesses.

Parameters:
TIMEOUT_CYCLES, 255, REQ cycles without ack before the access is aborted; 0 disables the timeout.
ADDR_W, 32, byte-address width.

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
mem_read  input  1  load requested this instruction (from decoder)
mem_write  input  1  store requested this instruction (from decoder)
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  ADDR_W  byte address from ALU
store_data  input  32  rs2 (or fs2) value
stall  output  1  core must hold PC and suppress regWrite
load_data  output  32  extended load result, valid when load_valid=1
load_valid  output  1  one-cycle pulse, load result ready
bus_req  output  1  access request, held until ack or timeout
bus_we  output  1  1 = write
bus_addr  output  ADDR_W  word-aligned address (addr[1:0] forced 00)
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  access complete; rdata valid for loads
bus_rdata  input  32  read word
fault  output  1  one-cycle pulse: misaligned, illegal funct3, read+write together, or timeout

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All registered outputs (bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, load_valid, fault) = 0. Timeout counter = 0.
- Reset asserted mid-access: bus_req=0 from the next edge; any in-flight ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, entry condition: mem_read^mem_write, legal funct3, aligned (H: addr[0]=0, W: addr[1:0]=0).
  - Latch bus_addr, bus_we, bus_be, bus_wdata, and the load size/sign.
  - Next state = REQ.
  - stall=1 combinationally in this cycle.
- IDLE, rejected request: mem_read&mem_write, illegal funct3 (store with funct3 other than 000/001/010, or load 011/11x), or misaligned.
  - fault=1 for the next cycle only.
  - No bus activity, stall=0, no load_valid; the instruction retires as a NOP for memory.
- REQ: bus_req=1, stall=1, bus_* held stable.
  - On bus_ack: capture the extended bus_rdata (loads) into load_data; next state = DONE.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES (if nonzero): drop bus_req, load_data=0, fault=1 in DONE, next state = DONE.
- DONE: stall=0, bus_req=0, load_valid=1 (loads only, including timeout). Core retires at the end of this cycle. Next state = IDLE.
  - A new request can therefore be seen in IDLE no earlier than DONE+1.
- Minimum latency: request cycle -> REQ -> DONE = 3 cycles when ack arrives in the first REQ cycle.
- bus_ack received while in IDLE or DONE is ignored.
- Byte enables:
  - B: 0001<<addr[1:0].
  - H: 0011<<addr[1:0].
  - W: 1111.
- Store data replication:
  - SB: {4{sd[7:0]}}.
  - SH: {2{sd[15:0]}}.
  - SW: sd.
- Load extraction: select the byte/half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). W passes through.

Test Plan:
- LW at 0x100, ack after 2 REQ cycles with rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, stall high 3 cycles, then load_valid=1, load_data=0xDEADBEEF.
- LB at 0x203 with rdata=0x80FF_0011, then LBU at the same address -> be=1000; load_data=0xFFFFFF80 then 0x00000080.
- SH at 0x302 with store_data=0x1234ABCD -> bus_we=1, be=1100, wdata=0xABCDABCD, no load_valid, stall released in DONE.
- LW at 0x101 (misaligned) and SB with funct3=011 -> fault pulse 1 cycle each, bus_req never asserted, stall=0.
- TIMEOUT_CYCLES=4, LW with no ack -> bus_req high exactly 4 cycles, then DONE with fault=1, load_valid=1, load_data=0; a late ack is ignored.
- rst_n=0 during REQ -> bus_req=0 and state=IDLE after the edge; a following SW completes normally.
